// File: rtl/hrange_pkg.sv
// hrange_pkg: shared types and helpers for the stepped range generator.
//   state_t : generator FSM states, also exposed on the top-level debug port
//   addr_w  : index width of a DEPTH-entry buffer
package hrange_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Pointer index width for a power-of-two buffer of the given depth (>= 2).
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/hrange_stepped_gen_fifo.sv
// gen_fifo: DEPTH-entry synchronous FIFO with flush, used as the output buffer.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : discard all entries (wins over push and pop)
//   i_push, i_din  : write an entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_full/o_empty : occupancy flags; o_last is high with exactly one entry
//   o_head         : head entry, meaningful only when !o_empty
module gen_fifo
  import hrange_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_last,
  output logic [W-1:0] o_head
);

  localparam int AW = addr_w(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  w_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_count   = r_wptr - r_rptr;
  assign o_full    = (w_count == (AW+1)'(DEPTH));
  assign o_empty   = (w_count == '0);
  assign o_last    = (w_count == (AW+1)'(1));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read behind the empty flag.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/hrange_stepped.sv
// hrange_stepped: generates Python range(start, stop, step) through a buffered
// _start/_ready/_valid/_done stream.
//   _clock, _reset     : clock, asynchronous active-low reset
//   _start             : capture start/stop/step, flush, begin a new range
//   start, stop, step  : signed range arguments (WIDTH bits)
//   _ready             : consumer takes the head element this cycle
//   _valid             : _out0/_out1 hold an element
//   _done              : one-cycle pulse once the range is generated and consumed
//   _error             : one-cycle pulse together with _done when step == 0
//   _out0, _out1       : element value and its zero-based index
//   o_dbg_state        : current FSM state
// Handshake: an element transfers on each rising edge where _valid && _ready;
// while _ready is low the head and _valid stay unchanged (except on _start or reset).
module hrange_stepped
  import hrange_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] start,
  input  logic signed [WIDTH-1:0] stop,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic                    _error,
  output logic signed [WIDTH-1:0] _out0,
  output logic [CNT_W-1:0]        _out1,
  output state_t                  o_dbg_state
);

  typedef struct packed {
    logic signed [WIDTH-1:0] value;
    logic [CNT_W-1:0]        index;
  } elem_t;

  localparam int EW = WIDTH + CNT_W;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [WIDTH-1:0] r_stop;
  logic signed [WIDTH-1:0] r_step;
  logic signed [WIDTH-1:0] r_i;
  logic [CNT_W-1:0]        r_k;
  logic                    r_done;
  logic                    r_error;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_last;
  elem_t                   w_head;
  elem_t                   w_din;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_advance;
  logic                    w_drained;
  logic                    w_done_nxt;
  logic                    w_error_nxt;

  // Next cursor one bit wider than the data so i + step cannot wrap; since
  // stop fits in WIDTH bits, any overflow lands past stop and ends the range.
  logic signed [WIDTH:0]   w_nxt;
  logic signed [WIDTH:0]   w_stop_x;
  logic                    w_step_pos;
  logic                    w_step_neg;
  logic                    w_cont;

  // Emptiness of the range presented on the inputs at _start.
  logic                    w_in_zero;
  logic                    w_in_empty;

  assign w_nxt      = {r_i[WIDTH-1], r_i} + {r_step[WIDTH-1], r_step};
  assign w_stop_x   = {r_stop[WIDTH-1], r_stop};
  assign w_step_neg = r_step[WIDTH-1];
  assign w_step_pos = !r_step[WIDTH-1] && (r_step != '0);
  assign w_cont     = (w_step_pos && (w_nxt < w_stop_x)) ||
                      (w_step_neg && (w_nxt > w_stop_x));

  assign w_in_zero  = (step == '0);
  assign w_in_empty = w_in_zero ||
                      (!step[WIDTH-1] && (start >= stop)) ||
                      (step[WIDTH-1]  && (start <= stop));

  assign w_pop      = _ready && _valid;
  assign w_drained  = w_empty || (w_last && w_pop);
  assign w_din      = '{value: r_i, index: r_k};

  gen_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (_clock),
    .i_rst_n (_reset),
    .i_flush (_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_last  (w_last),
    .o_head  (w_head)
  );

  // State register and datapath registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      r_state <= IDLE;
      r_stop  <= '0;
      r_step  <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
      if (_start) begin
        r_stop <= stop;
        r_step <= step;
        r_i    <= start;
        r_k    <= '0;
      end else if (w_advance) begin
        r_i <= w_nxt[WIDTH-1:0];
        r_k <= r_k + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (_start) begin
      w_state_nxt = w_in_empty ? IDLE : GEN;
    end else begin
      case (r_state)
        GEN:     if (!w_full && !w_cont) w_state_nxt = DRAIN;
        DRAIN:   if (w_drained)          w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output / control decode.
  always_comb begin
    w_push      = 1'b0;
    w_advance   = 1'b0;
    w_done_nxt  = 1'b0;
    w_error_nxt = 1'b0;
    if (_start) begin
      w_done_nxt  = w_in_empty;
      w_error_nxt = w_in_zero;
    end else begin
      w_push     = (r_state == GEN) && !w_full;
      w_advance  = w_push && w_cont;
      w_done_nxt = (r_state == DRAIN) && w_drained;
    end
  end

  // Outputs read zero whenever no element is held, including during reset.
  assign _valid      = !w_empty;
  assign _out0       = _valid ? w_head.value : '0;
  assign _out1       = _valid ? w_head.index : '0;
  assign _done       = r_done;
  assign _error      = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hrange_stepped.sv
module tb_hrange_stepped;
  import hrange_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                    start_i;
  logic signed [WIDTH-1:0] start_v, stop_v, step_v;
  logic                    ready;
  logic                    valid, done, error;
  logic signed [WIDTH-1:0] out0;
  logic [CNT_W-1:0]        out1;
  state_t                  dbg_state;

  hrange_stepped #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    ._clock      (clk),
    ._reset      (rst_n),
    ._start      (start_i),
    .start       (start_v),
    .stop        (stop_v),
    .step        (step_v),
    ._ready      (ready),
    ._valid      (valid),
    ._done       (done),
    ._error      (error),
    ._out0       (out0),
    ._out1       (out1),
    .o_dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected {value, index} pairs in order.
  logic [WIDTH+CNT_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: Python range semantics on plain integers.
  task automatic fill(input int s, input int e, input int st);
    int k;
    int v;
    exp_q.delete();
    k = 0;
    if (st > 0) begin
      for (v = s; v < e; v += st) begin
        exp_q.push_back({v[WIDTH-1:0], k[CNT_W-1:0]});
        k++;
      end
    end else if (st < 0) begin
      for (v = s; v > e; v += st) begin
        exp_q.push_back({v[WIDTH-1:0], k[CNT_W-1:0]});
        k++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: present a new range for the next rising edge.
  task automatic start_range(input int s, input int e, input int st);
    start_v = WIDTH'(s);
    stop_v  = WIDTH'(e);
    step_v  = WIDTH'(st);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Consume the stream until _done. mode 0: _ready held high (timing checked
  // against exp_n), mode 1: _ready random.
  task automatic monitor(input int mode, input bit exp_err, input int exp_n);
    int  cyc;
    bit  got_done;
    bit  prev_hold;
    logic [WIDTH+CNT_W-1:0] prev_el;
    logic [WIDTH+CNT_W-1:0] exp_el;
    cyc = 0;
    got_done = 1'b0;
    prev_hold = 1'b0;
    prev_el = '0;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_hold) begin
        check("head_valid_stable", valid, 1);
        check("head_stable", {out0, out1}, prev_el);
      end
      ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (done) begin
        got_done = 1'b1;
        check("valid_with_done", valid, 0);
        check("error_at_done", error, exp_err);
        check("left_in_queue", exp_q.size(), 0);
        if (mode == 0) check("done_cycle", cyc, (exp_n == 0) ? 1 : exp_n + 2);
      end else begin
        check("error_early", error, 0);
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            check("extra_element", {out0, out1}, 32'hFFFF_FFFF);
          end else begin
            exp_el = exp_q.pop_front();
            check("element", {out0, out1}, exp_el);
          end
        end
        prev_hold = valid && !ready;
        prev_el = {out0, out1};
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("error_one_cycle", error, 0);
    check("idle_valid", valid, 0);
  endtask

  task automatic run(input int s, input int e, input int st, input int mode);
    fill(s, e, st);
    start_range(s, e, st);
    monitor(mode, st == 0, exp_q.size());
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pops;
    int rs, re, rst_step;
    logic [WIDTH-1:0] b;
    logic [WIDTH+CNT_W-1:0] exp_el;

    rst_n = 1'b0;
    start_i = 1'b0;
    start_v = '0;
    stop_v = '0;
    step_v = '0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, descending, empty and step-zero ranges.
    run(0, 5, 1, 0);
    run(10, 0, -3, 0);
    run(10, 0, 3, 0);
    run(3, 3, 1, 0);
    run(3, 9, 0, 0);

    // Edges of the 8-bit range: termination without wrap.
    run(120, 127, 5, 0);
    run(-125, -128, -2, 0);
    run(100, 127, 27, 0);

    // Back-pressure.
    run(0, 20, 1, 1);
    run(-7, 30, 4, 1);

    // Random ranges under random back-pressure.
    for (int t = 0; t < 8; t++) begin
      b = WIDTH'($urandom_range(0, 255));
      rs = int'($signed(b));
      b = WIDTH'($urandom_range(0, 255));
      re = int'($signed(b));
      rst_step = int'($urandom_range(0, 12)) - 6;
      run(rs, re, rst_step, 1);
    end

    // Restart mid-range, with the third pop on the same edge as _start.
    fill(0, 100, 1);
    start_range(0, 100, 1);
    pops = 0;
    for (int c = 0; c < 20 && pops < 3; c++) begin
      @(negedge clk);
      ready = 1'b1;
      check("restart_no_done", done, 0);
      if (valid) begin
        exp_el = exp_q.pop_front();
        check("restart_first", {out0, out1}, exp_el);
        pops++;
      end
    end
    check("restart_pops", pops, 3);
    fill(50, 52, 1);
    start_range(50, 52, 1);
    monitor(0, 1'b0, 2);

    // Reset between edges mid-range.
    @(negedge clk);
    fill(0, 100, 1);
    start_range(0, 100, 1);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_out0", out0, 0);
    check("mid_rst_out1", out1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_valid", valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
